// File: rtl/painterengine_gpu_dma_pkg.sv
// Shared definitions for the PainterEngine GPU DMA engines (writer and reader):
// FSM states, error codes, page geometry and fixed AXI4 attribute values.
package painterengine_gpu_dma_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_CALC0,
    ST_CALC1,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE,
    ST_ERR
  } dma_state_e;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_ROUTER     = 3'd1;
  localparam logic [2:0] ERR_ALIGN      = 3'd2;
  localparam logic [2:0] ERR_LENGTH     = 3'd3;
  localparam logic [2:0] ERR_AW_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_W_TIMEOUT  = 3'd5;
  localparam logic [2:0] ERR_BRESP      = 3'd6;
  localparam logic [2:0] ERR_B_TIMEOUT  = 3'd7;

  localparam int unsigned PAGE_BYTES = 4096;
  localparam int unsigned PAGE_BITS  = 12;

  localparam logic [0:0] AXI_ID         = 1'b0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic       AXI_LOCK       = 1'b0;
  localparam logic [3:0] AXI_CACHE      = 4'b0010;
  localparam logic [2:0] AXI_PROT       = 3'b000;
  localparam logic [3:0] AXI_QOS        = 4'b0000;

  // AXI AxSIZE encoding for a beat of the given data width
  function automatic logic [2:0] axi_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/painterengine_gpu_dma_burst_calc.sv
// Two-stage registered burst planner: beat address from base+offset, then the
// largest burst bounded by remaining beats, the burst limit and the 4 KB page.
module painterengine_gpu_dma_burst_calc
  import painterengine_gpu_dma_pkg::*;
#(
  parameter int unsigned PARAM_DATA_WIDTH = 32,
  parameter int unsigned PARAM_MAX_BURST  = 256
) (
  input  logic        i_wire_clock,
  input  logic [31:0] i_wire_address,
  input  logic [31:0] i_wire_offset,
  input  logic [31:0] i_wire_length,
  output logic [31:0] o_wire_address,
  output logic [8:0]  o_wire_burst
);

  localparam int unsigned SIZE      = $clog2(PARAM_DATA_WIDTH / 8);
  localparam logic [8:0]  MAX_BEATS = 9'(PARAM_MAX_BURST);

  logic [31:0] waddr_q;
  logic [31:0] remain_q;
  logic [12:0] page_bytes;
  logic [12:0] page_beats;
  logic [8:0]  remain_sat;
  logic [8:0]  page_sat;
  logic [8:0]  burst_d;

  always_ff @(posedge i_wire_clock) begin
    waddr_q  <= i_wire_address + (i_wire_offset << SIZE);
    remain_q <= i_wire_length - i_wire_offset;
  end

  // Both operands saturate at 256 so the min() fits a 9-bit compare
  always_comb begin
    page_bytes = 13'(PAGE_BYTES) - {1'b0, waddr_q[PAGE_BITS-1:0]};
    page_beats = page_bytes >> SIZE;
    remain_sat = (remain_q > 32'd256) ? 9'd256 : remain_q[8:0];
    page_sat   = (page_beats > 13'd256) ? 9'd256 : page_beats[8:0];
    burst_d    = remain_sat;
    if (MAX_BEATS < burst_d) burst_d = MAX_BEATS;
    if (page_sat < burst_d)  burst_d = page_sat;
  end

  always_ff @(posedge i_wire_clock) begin
    o_wire_address <= waddr_q;
    o_wire_burst   <= burst_d;
  end

endmodule

// File: rtl/painterengine_gpu_dma_burst_writer.sv
// AXI4 write-master DMA: selects one requester channel and streams its data to
// memory as page-safe INCR bursts, one burst outstanding at a time.
module painterengine_gpu_dma_burst_writer
  import painterengine_gpu_dma_pkg::*;
#(
  parameter int unsigned PARAM_CHANNELS   = 4,
  parameter int unsigned PARAM_DATA_WIDTH = 32,
  parameter int unsigned PARAM_MAX_BURST  = 256,
  parameter int unsigned PARAM_TIMEOUT    = 256
) (
  input  logic                                   i_wire_clock,
  input  logic                                   i_wire_reset,
  input  logic [PARAM_CHANNELS-1:0]              i_wire_router,
  input  logic [32*PARAM_CHANNELS-1:0]           i_wire_address,
  input  logic [32*PARAM_CHANNELS-1:0]           i_wire_length,
  input  logic [PARAM_DATA_WIDTH*PARAM_CHANNELS-1:0] i_wire_data,
  input  logic [PARAM_CHANNELS-1:0]              i_wire_data_valid,
  output logic [PARAM_CHANNELS-1:0]              o_wire_data_next,
  output logic                                   o_wire_done,
  output logic                                   o_wire_error,
  output logic [2:0]                             o_wire_error_type,
  output logic [0:0]                             o_wire_M_AXI_AWID,
  output logic [31:0]                            o_wire_M_AXI_AWADDR,
  output logic [7:0]                             o_wire_M_AXI_AWLEN,
  output logic [2:0]                             o_wire_M_AXI_AWSIZE,
  output logic [1:0]                             o_wire_M_AXI_AWBURST,
  output logic                                   o_wire_M_AXI_AWLOCK,
  output logic [3:0]                             o_wire_M_AXI_AWCACHE,
  output logic [2:0]                             o_wire_M_AXI_AWPROT,
  output logic [3:0]                             o_wire_M_AXI_AWQOS,
  output logic                                   o_wire_M_AXI_AWVALID,
  input  logic                                   i_wire_M_AXI_AWREADY,
  output logic [PARAM_DATA_WIDTH-1:0]            o_wire_M_AXI_WDATA,
  output logic [PARAM_DATA_WIDTH/8-1:0]          o_wire_M_AXI_WSTRB,
  output logic                                   o_wire_M_AXI_WLAST,
  output logic                                   o_wire_M_AXI_WVALID,
  input  logic                                   i_wire_M_AXI_WREADY,
  input  logic [0:0]                             i_wire_M_AXI_BID,
  input  logic [1:0]                             i_wire_M_AXI_BRESP,
  input  logic                                   i_wire_M_AXI_BVALID,
  output logic                                   o_wire_M_AXI_BREADY
);

  localparam int unsigned CH_W  = (PARAM_CHANNELS > 1) ? $clog2(PARAM_CHANNELS) : 1;
  localparam int unsigned SIZE  = $clog2(PARAM_DATA_WIDTH / 8);
  localparam int unsigned TMR_W = $clog2(PARAM_TIMEOUT + 1);

  dma_state_e state_q, state_d;
  logic [2:0]       err_q, err_d;
  logic [CH_W-1:0]  ch_q;
  logic [31:0]      addr_q;
  logic [31:0]      len_q;
  logic [31:0]      offset_q;
  logic [8:0]       beat_q;
  logic             wlast_q;
  logic [TMR_W-1:0] timer_q;

  logic [3:0]                  router_count;
  logic [CH_W-1:0]             router_index;
  logic                        router_onehot;
  logic [31:0]                 sel_addr;
  logic [31:0]                 sel_len;
  logic [PARAM_DATA_WIDTH-1:0] ch_data;
  logic                        ch_valid;
  logic [31:0]                 calc_addr;
  logic [8:0]                  calc_burst;
  logic                        aw_fire, w_fire, b_fire, expire;

  always_comb begin
    router_count = '0;
    router_index = '0;
    sel_addr     = '0;
    sel_len      = '0;
    for (int unsigned i = 0; i < PARAM_CHANNELS; i++) begin
      if (i_wire_router[i]) begin
        router_count = router_count + 4'd1;
        router_index = CH_W'(i);
        sel_addr     = i_wire_address[i*32 +: 32];
        sel_len      = i_wire_length[i*32 +: 32];
      end
    end
    router_onehot = (router_count == 4'd1);
  end

  always_comb begin
    ch_data  = i_wire_data[PARAM_DATA_WIDTH-1:0];
    ch_valid = 1'b0;
    for (int unsigned i = 0; i < PARAM_CHANNELS; i++) begin
      if (CH_W'(i) == ch_q) begin
        ch_data  = i_wire_data[i*PARAM_DATA_WIDTH +: PARAM_DATA_WIDTH];
        ch_valid = i_wire_data_valid[i];
      end
    end
  end

  painterengine_gpu_dma_burst_calc #(
    .PARAM_DATA_WIDTH(PARAM_DATA_WIDTH),
    .PARAM_MAX_BURST (PARAM_MAX_BURST)
  ) u_calc (
    .i_wire_clock  (i_wire_clock),
    .i_wire_address(addr_q),
    .i_wire_offset (offset_q),
    .i_wire_length (len_q),
    .o_wire_address(calc_addr),
    .o_wire_burst  (calc_burst)
  );

  // A response carrying a foreign ID is not ours; it is left to time out
  assign aw_fire = (state_q == ST_AW) && i_wire_M_AXI_AWREADY;
  assign w_fire  = (state_q == ST_W) && ch_valid && i_wire_M_AXI_WREADY;
  assign b_fire  = (state_q == ST_B) && i_wire_M_AXI_BVALID && (i_wire_M_AXI_BID == AXI_ID);
  assign expire  = (timer_q == TMR_W'(PARAM_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_wire_router != '0) begin
          if (router_onehot) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_ERR;
            err_d   = ERR_ROUTER;
          end
        end
      end
      ST_CHECK: begin
        if (addr_q[SIZE-1:0] != '0) begin
          state_d = ST_ERR;
          err_d   = ERR_ALIGN;
        end else if (len_q == '0) begin
          state_d = ST_ERR;
          err_d   = ERR_LENGTH;
        end else begin
          state_d = ST_CALC0;
        end
      end
      ST_CALC0: state_d = ST_CALC1;
      ST_CALC1: state_d = ST_AW;
      ST_AW: begin
        if (aw_fire) begin
          state_d = ST_W;
        end else if (expire) begin
          state_d = ST_ERR;
          err_d   = ERR_AW_TIMEOUT;
        end
      end
      ST_W: begin
        if (w_fire) begin
          if (wlast_q) state_d = ST_B;
        end else if (expire) begin
          state_d = ST_ERR;
          err_d   = ERR_W_TIMEOUT;
        end
      end
      ST_B: begin
        if (b_fire) begin
          if (i_wire_M_AXI_BRESP[1]) begin
            state_d = ST_ERR;
            err_d   = ERR_BRESP;
          end else if (offset_q >= len_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC0;
          end
        end else if (expire) begin
          state_d = ST_ERR;
          err_d   = ERR_B_TIMEOUT;
        end
      end
      ST_DONE, ST_ERR: begin
        if (i_wire_router == '0) begin
          state_d = ST_IDLE;
          err_d   = ERR_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state_q  <= ST_IDLE;
      err_q    <= ERR_NONE;
      ch_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      offset_q <= '0;
      beat_q   <= '0;
      wlast_q  <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (state_q == ST_IDLE && router_onehot) begin
        ch_q   <= router_index;
        addr_q <= sel_addr;
        len_q  <= sel_len;
      end
      if ((state_q == ST_DONE || state_q == ST_ERR) && state_d == ST_IDLE) begin
        offset_q <= '0;
      end
      if (aw_fire) begin
        beat_q  <= '0;
        wlast_q <= (calc_burst == 9'd1);
      end
      // WLAST is staged one beat ahead so it lines up with the final beat
      if (w_fire) begin
        if (wlast_q) begin
          wlast_q  <= 1'b0;
          offset_q <= offset_q + 32'(calc_burst);
        end else begin
          beat_q  <= beat_q + 9'd1;
          wlast_q <= (beat_q + 9'd2 == calc_burst);
        end
      end
      if (state_d != state_q || aw_fire || w_fire || b_fire) begin
        timer_q <= '0;
      end else if (state_q == ST_AW || state_q == ST_W || state_q == ST_B) begin
        timer_q <= timer_q + 1'b1;
      end else begin
        timer_q <= '0;
      end
    end
  end

  always_comb begin
    o_wire_data_next = '0;
    for (int unsigned i = 0; i < PARAM_CHANNELS; i++) begin
      o_wire_data_next[i] = w_fire && (CH_W'(i) == ch_q);
    end
  end

  assign o_wire_done       = (state_q == ST_DONE);
  assign o_wire_error      = (state_q == ST_ERR);
  assign o_wire_error_type = err_q;

  assign o_wire_M_AXI_AWID    = AXI_ID;
  assign o_wire_M_AXI_AWADDR  = calc_addr;
  assign o_wire_M_AXI_AWLEN   = 8'(calc_burst - 9'd1);
  assign o_wire_M_AXI_AWSIZE  = axi_size(PARAM_DATA_WIDTH);
  assign o_wire_M_AXI_AWBURST = AXI_BURST_INCR;
  assign o_wire_M_AXI_AWLOCK  = AXI_LOCK;
  assign o_wire_M_AXI_AWCACHE = AXI_CACHE;
  assign o_wire_M_AXI_AWPROT  = AXI_PROT;
  assign o_wire_M_AXI_AWQOS   = AXI_QOS;
  assign o_wire_M_AXI_AWVALID = (state_q == ST_AW);

  assign o_wire_M_AXI_WDATA  = ch_data;
  assign o_wire_M_AXI_WSTRB  = '1;
  assign o_wire_M_AXI_WLAST  = wlast_q && (state_q == ST_W);
  assign o_wire_M_AXI_WVALID = (state_q == ST_W) && ch_valid;

  assign o_wire_M_AXI_BREADY = (state_q == ST_B);

endmodule

// File: tb/tb_painterengine_gpu_dma_burst_writer.sv
// Scoreboard bench for the burst writer: a reference planner queues the expected
// AW/W/outcome stream; a slave/monitor process consumes and compares it.
module tb_painterengine_gpu_dma_burst_writer;

  localparam int unsigned MAXB = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   router;
  logic [127:0] address, length, data;
  logic [3:0]   data_valid, data_next;
  logic         done, error;
  logic [2:0]   etype;
  logic [0:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize, awprot;
  logic [1:0]   awburst;
  logic         awlock, awvalid, awready;
  logic [3:0]   awcache, awqos, wstrb;
  logic [31:0]  wdata;
  logic         wlast, wvalid, wready;
  logic [0:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid, bready;

  always #5 clk = ~clk;

  painterengine_gpu_dma_burst_writer #(
    .PARAM_CHANNELS(4), .PARAM_DATA_WIDTH(32), .PARAM_MAX_BURST(256), .PARAM_TIMEOUT(256)
  ) dut (
    .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_router(router),
    .i_wire_address(address), .i_wire_length(length), .i_wire_data(data),
    .i_wire_data_valid(data_valid), .o_wire_data_next(data_next),
    .o_wire_done(done), .o_wire_error(error), .o_wire_error_type(etype),
    .o_wire_M_AXI_AWID(awid), .o_wire_M_AXI_AWADDR(awaddr), .o_wire_M_AXI_AWLEN(awlen),
    .o_wire_M_AXI_AWSIZE(awsize), .o_wire_M_AXI_AWBURST(awburst), .o_wire_M_AXI_AWLOCK(awlock),
    .o_wire_M_AXI_AWCACHE(awcache), .o_wire_M_AXI_AWPROT(awprot), .o_wire_M_AXI_AWQOS(awqos),
    .o_wire_M_AXI_AWVALID(awvalid), .i_wire_M_AXI_AWREADY(awready),
    .o_wire_M_AXI_WDATA(wdata), .o_wire_M_AXI_WSTRB(wstrb), .o_wire_M_AXI_WLAST(wlast),
    .o_wire_M_AXI_WVALID(wvalid), .i_wire_M_AXI_WREADY(wready),
    .i_wire_M_AXI_BID(bid), .i_wire_M_AXI_BRESP(bresp), .i_wire_M_AXI_BVALID(bvalid),
    .o_wire_M_AXI_BREADY(bready)
  );

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [31:0] data; logic last; } w_t;

  aw_t         exp_aw[$];
  w_t          exp_w[$];
  logic [4:0]  exp_res[$];   // {done, error, error_type}
  logic [31:0] src_data[$];
  int unsigned src_idx = 0;
  int unsigned tb_ch = 0, awr_pct = 100, wr_pct = 100, dv_pct = 100;
  bit          stuck = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00;
  int unsigned w_seen = 0;
  int unsigned pending_b = 0;
  int unsigned errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Slave responder, data source and scoreboard monitor
  initial begin
    bit   aw_hs, w_hs, b_hs, cur, prev_out;
    aw_t  a;
    w_t   w;
    logic [4:0] r;
    prev_out = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 1'b0;
    data = '0; data_valid = '0;
    forever begin
      @(negedge clk);
      aw_hs = awvalid && awready && !rst;
      w_hs  = wvalid && wready && !rst;
      b_hs  = bvalid && bready && !rst;
      if (aw_hs) begin
        chk("aw_fields", 64'({awid, awsize, awburst, awlock, awcache, awprot, awqos}),
            64'({1'b0, 3'd2, 2'b01, 1'b0, 4'b0010, 3'd0, 4'd0}));
        chk("aw_in_page", 64'((awaddr % 4096) + (awlen + 1) * 4 <= 4096), 64'd1);
        if (exp_aw.size() == 0) chk("aw_unexpected", 64'(awaddr), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          a = exp_aw.pop_front();
          chk("awaddr", 64'(awaddr), 64'(a.addr));
          chk("awlen", 64'(awlen), 64'(a.len));
        end
      end
      if (!rst) chk("data_next", 64'(data_next), w_hs ? (64'd1 << tb_ch) : 64'd0);
      if (w_hs) begin
        w_seen++;
        if (wlast) pending_b++;
        chk("wstrb", 64'(wstrb), 64'hF);
        if (exp_w.size() == 0) chk("w_unexpected", 64'(wdata), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          w = exp_w.pop_front();
          chk("wdata", 64'(wdata), 64'(w.data));
          chk("wlast", 64'(wlast), 64'(w.last));
        end
      end
      cur = done || error;
      if (cur && !prev_out) begin
        if (exp_res.size() == 0) chk("outcome_unexpected", 64'({done, error, etype}), 64'h1F);
        else begin
          r = exp_res.pop_front();
          chk("outcome", 64'({done, error, etype}), 64'(r));
        end
      end
      prev_out = cur;
      @(posedge clk);
      #1;
      if (w_hs) src_idx++;
      if (b_hs) bvalid = 1'b0;
      else if (!bvalid && pending_b > 0 && $urandom_range(99) < 60) begin
        bvalid = 1'b1;
        pending_b--;
      end
      bresp   = bresp_cfg;
      awready = ($urandom_range(99) < awr_pct);
      wready  = !stuck && ($urandom_range(99) < wr_pct);
      data    = {$urandom, $urandom, $urandom, $urandom};
      data_valid = '0;
      if (src_idx < src_data.size()) begin
        data[tb_ch*32 +: 32] = src_data[src_idx];
        data_valid[tb_ch]    = ($urandom_range(99) < dv_pct);
      end
    end
  end

  // Reference planner: page-bounded bursts derived directly from the rules
  task automatic start_xfer(input int unsigned ch, input logic [3:0] rt, input logic [31:0] addr,
                            input int unsigned len, input int unsigned awr, input int unsigned wr,
                            input int unsigned dvr, input logic [1:0] br, input bit stk);
    int unsigned off, b, page;
    logic [31:0] wa;
    logic [4:0]  res;
    aw_t a;
    w_t  w;
    src_data.delete();
    for (int unsigned i = 0; i < len; i++) src_data.push_back($urandom);
    src_idx = 0; tb_ch = ch; awr_pct = awr; wr_pct = wr; dv_pct = dvr;
    bresp_cfg = br; stuck = stk;
    if ($countones(rt) != 1) res = 5'b01001;
    else if (addr % 4 != 0) res = 5'b01010;
    else if (len == 0) res = 5'b01011;
    else begin
      res = 5'b10000;
      off = 0;
      while (off < len) begin
        wa = addr + off * 4;
        page = (4096 - (wa % 4096)) / 4;
        b = len - off;
        if (b > MAXB) b = MAXB;
        if (b > page) b = page;
        a.addr = wa; a.len = 8'(b - 1);
        exp_aw.push_back(a);
        if (stk) begin res = 5'b01101; break; end
        for (int unsigned i = 0; i < b; i++) begin
          w.data = src_data[off + i]; w.last = (i == b - 1);
          exp_w.push_back(w);
        end
        if (br[1]) begin res = 5'b01110; break; end
        off += b;
      end
    end
    exp_res.push_back(res);
    @(posedge clk);
    #1;
    address = {$urandom, $urandom, $urandom, $urandom};
    length  = {$urandom, $urandom, $urandom, $urandom};
    address[ch*32 +: 32] = addr;
    length[ch*32 +: 32]  = len;
    router = rt;
  endtask

  task automatic finish_xfer(input string nm);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (done || error) begin seen = 1'b1; break; end
    end
    chk({nm, "_completes"}, 64'(seen), 64'd1);
    @(negedge clk);
    chk({nm, "_aw_left"}, 64'(exp_aw.size()), 64'd0);
    chk({nm, "_w_left"}, 64'(exp_w.size()), 64'd0);
    chk({nm, "_res_left"}, 64'(exp_res.size()), 64'd0);
    @(posedge clk);
    #1 router = '0;
    repeat (2) @(negedge clk);
    chk({nm, "_idle"}, 64'({done, error, etype}), 64'd0);
    exp_aw.delete(); exp_w.delete(); exp_res.delete();
  endtask

  task automatic run(input string nm, input int unsigned ch, input logic [3:0] rt,
                     input logic [31:0] addr, input int unsigned len, input int unsigned awr,
                     input int unsigned wr, input int unsigned dvr, input logic [1:0] br,
                     input bit stk);
    start_xfer(ch, rt, addr, len, awr, wr, dvr, br, stk);
    finish_xfer(nm);
  endtask

  initial begin
    int unsigned w0;
    bit reached;
    rst = 1'b1; router = '0; address = '0; length = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 64'({awvalid, wvalid, wlast, bready, done, error, etype, data_next}), 64'd0);

    run("single16",  2, 4'b0100, 32'h0000_1000, 16,  100, 100, 100, 2'b00, 1'b0);
    run("len600",    0, 4'b0001, 32'h0000_0000, 600, 100, 100, 100, 2'b00, 1'b0);
    run("pagesplit", 1, 4'b0010, 32'h0000_0FF0, 16,  100, 100, 100, 2'b00, 1'b0);
    run("gaps",      3, 4'b1000, 32'h0000_2000, 16,  50,  60,  60,  2'b01, 1'b0);

    run("err_align", 0, 4'b0001, 32'h0000_1002, 16,  100, 100, 100, 2'b00, 1'b0);
    run("ok_a",      1, 4'b0010, 32'h0000_0100, 8,   100, 100, 100, 2'b00, 1'b0);
    run("err_route", 0, 4'b0011, 32'h0000_1000, 16,  100, 100, 100, 2'b00, 1'b0);
    run("ok_b",      3, 4'b1000, 32'h0000_0200, 8,   100, 100, 100, 2'b00, 1'b0);
    run("err_len0",  2, 4'b0100, 32'h0000_1000, 0,   100, 100, 100, 2'b00, 1'b0);
    run("ok_c",      0, 4'b0001, 32'h0000_0300, 8,   100, 100, 100, 2'b00, 1'b0);
    run("err_bresp", 1, 4'b0010, 32'h0000_3000, 16,  100, 100, 100, 2'b10, 1'b0);
    run("ok_d",      2, 4'b0100, 32'h0000_0400, 8,   100, 100, 100, 2'b00, 1'b0);
    run("err_wto",   3, 4'b1000, 32'h0000_4000, 16,  100, 0,   100, 2'b00, 1'b1);
    run("ok_e",      1, 4'b0010, 32'h0000_0500, 8,   100, 100, 100, 2'b00, 1'b0);

    // Reset while the fifth of sixteen beats is on the bus
    start_xfer(1, 4'b0010, 32'h0000_0000, 16, 100, 100, 100, 2'b00, 1'b0);
    w0 = w_seen;
    reached = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (w_seen - w0 >= 4) begin reached = 1'b1; break; end
    end
    chk("midburst_reached", 64'(reached), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1; router = '0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_abort", 64'({awvalid, wvalid, wlast, bready, done, error, data_next}), 64'd0);
    exp_aw.delete(); exp_w.delete(); exp_res.delete(); src_data.delete();
    repeat (2) @(negedge clk);
    chk("reset_stays_idle", 64'({awvalid, wvalid, bready, done, error}), 64'd0);
    run("after_reset", 0, 4'b0001, 32'h0000_0800, 16, 100, 100, 100, 2'b00, 1'b0);

    for (int k = 0; k < 6; k++) begin
      int unsigned ch;
      logic [31:0] ad;
      ch = $urandom_range(3);
      ad = ($urandom_range(3) << 12) | ($urandom_range(990, 1023) << 2);
      run("random", ch, 4'(1 << ch), ad, $urandom_range(1, 40), $urandom_range(60, 100),
          $urandom_range(40, 100), $urandom_range(40, 100), 2'(2 * $urandom_range(0, 1) - 0) & 2'b01, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
